// File: rtl/sensor_guard_multi_if.sv
// Bundle of the tick, arm, clear and sample inputs, and the relay and fault status
// outputs shared between the sampling front-end and the supervisor.
interface sensor_guard_multi_if #(
  parameter int N_CH = 4,
  parameter int W    = 16
);
  logic              enable;
  logic              arm;
  logic [N_CH-1:0]   clear;
  logic [N_CH*W-1:0] sen;
  logic [N_CH-1:0]   relay_out;
  logic [N_CH-1:0]   fault_latched;
  logic              any_fault;
  logic [N_CH*4-1:0] retry_cnt;

  modport master (
    output enable, arm, clear, sen,
    input  relay_out, fault_latched, any_fault, retry_cnt
  );

  modport slave (
    input  enable, arm, clear, sen,
    output relay_out, fault_latched, any_fault, retry_cnt
  );
endinterface

// File: rtl/sensor_guard_multi.sv
// Multi-channel relay supervisor: each channel debounces an out-of-window sample,
// opens its relay, retries after a hold-off and latches a fault after MAX_RETRY trips.
module sensor_guard_multi #(
  parameter int N_CH       = 4,
  parameter int W          = 16,
  parameter int SEN_REF    = 350,
  parameter int THRESHOLD  = 100,
  parameter int DEBOUNCE   = 3,
  parameter int WAIT_TICKS = 312,
  parameter int MAX_RETRY  = 3
) (
  input logic                 clk,
  input logic                 rst,
  sensor_guard_multi_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(WAIT_TICKS + 1);

  localparam logic [W-1:0]  SEN_REF_W   = W'(SEN_REF);
  localparam logic [W-1:0]  THRESHOLD_W = W'(THRESHOLD);
  localparam logic [DW-1:0] DBC_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(WAIT_TICKS - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAR = 3'd1,
    S_OPEN = 3'd2,
    S_WAIT = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  logic [N_CH-1:0]   relay_vec;
  logic [N_CH-1:0]   fault_vec;
  logic [N_CH*4-1:0] cnt_vec;
  logic              any_fault_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W-1:0]  sample;
      logic [W-1:0]  diff;
      logic          fail;
      state_t        state_reg, state_next;
      logic [DW-1:0] dbc_reg, dbc_next;
      logic [TW-1:0] timer_reg, timer_next;
      logic [3:0]    cnt_reg, cnt_next;
      logic          relay_reg;
      logic          fault_reg;

      assign sample = bus.sen[gi*W +: W];
      assign diff   = (sample > SEN_REF_W) ? (sample - SEN_REF_W) : (SEN_REF_W - sample);
      assign fail   = diff > THRESHOLD_W;

      always_comb begin
        state_next = state_reg;
        dbc_next   = dbc_reg;
        timer_next = timer_reg;
        cnt_next   = cnt_reg;
        if (bus.clear[gi]) begin
          // Acknowledge overrides whatever transition the channel was about to take.
          state_next = S_IDLE;
          dbc_next   = '0;
          timer_next = '0;
          cnt_next   = '0;
        end else begin
          case (state_reg)
            S_IDLE: begin
              dbc_next   = '0;
              timer_next = '0;
              cnt_next   = '0;
              if (bus.arm) state_next = S_HEAR;
            end
            S_HEAR: begin
              if (fail) begin
                dbc_next = dbc_reg + DW'(1);
                if (dbc_reg == DBC_LAST) state_next = S_OPEN;
              end else begin
                dbc_next = '0;
              end
            end
            S_OPEN: begin
              cnt_next   = cnt_reg + 4'd1;
              timer_next = '0;
              state_next = S_WAIT;
            end
            S_WAIT: begin
              timer_next = timer_reg + TW'(1);
              if (timer_reg == TIMER_LAST) begin
                if (cnt_reg == RETRY_MAX) begin
                  state_next = S_FAIL;
                end else begin
                  dbc_next   = '0;
                  state_next = S_HEAR;
                end
              end
            end
            S_FAIL: state_next = S_FAIL;
            default: begin
              state_next = S_IDLE;
              dbc_next   = '0;
              timer_next = '0;
              cnt_next   = '0;
            end
          endcase
        end
      end

      // Outputs are registered from the next state so they line up with the state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= S_IDLE;
          dbc_reg   <= '0;
          timer_reg <= '0;
          cnt_reg   <= '0;
          relay_reg <= 1'b0;
          fault_reg <= 1'b0;
        end else if (bus.enable) begin
          state_reg <= state_next;
          dbc_reg   <= dbc_next;
          timer_reg <= timer_next;
          cnt_reg   <= cnt_next;
          relay_reg <= (state_next == S_WAIT) || (state_next == S_FAIL);
          fault_reg <= (state_next == S_FAIL);
        end
      end

      assign relay_vec[gi]        = relay_reg;
      assign fault_vec[gi]        = fault_reg;
      assign cnt_vec[gi*4 +: 4]   = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      any_fault_reg <= 1'b0;
    end else begin
      any_fault_reg <= |fault_vec;
    end
  end

  assign bus.relay_out     = relay_vec;
  assign bus.fault_latched = fault_vec;
  assign bus.retry_cnt     = cnt_vec;
  assign bus.any_fault     = any_fault_reg;
endmodule
